// File: rtl/rf_pkg.sv
// ============================================================================
// rf_pkg : shared types and constants for the register-file write-port logic
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    ARB  = 1'b1
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin grant, search starts at ptr and wraps
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Outer loop walks priority distance from ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter : clears x1..x31 after reset, then round-robins the RF write port
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int XLEN           = rf_pkg::XLEN,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [XLEN*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           init_busy,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]                rf_wdata
);

  localparam int                    PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [REG_ADDR_W-1:0] LAST_REG    = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR    = PTR_W'(NUM_REQ - 1);
  localparam wb_state_e             RESET_STATE = CLEAR_ON_RESET ? INIT : ARB;

  wb_state_e               state_q, state_d;
  logic [REG_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;

  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_any;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [XLEN-1:0]         sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // One-hot grant lets the payload mux be a plain AND-OR.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= REG_ADDR_W'(1);
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == INIT) && (cnt_q == LAST_REG)) begin
      state_d = ARB;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + 1'b1;
      end
      ARB: begin
        if (grant_any) begin
          // x0 is hardwired zero: accept the request but suppress the strobe.
          we_d    = (sel_addr != '0);
          waddr_d = sel_addr;
          wdata_d = sel_data;
          ptr_d   = (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    init_busy = (state_q == INIT);
    req_ready = (state_q == ARB) ? grant : '0;
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// tb_rf_wb_arbiter : scoreboard bench for rf_wb_arbiter (clear and no-clear builds)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XL   = 32;

  logic            clk;
  logic            rst_n;

  logic [NREQ-1:0]   va, vb;
  logic [5*NREQ-1:0] aa, ab;
  logic [XL*NREQ-1:0] da, db;
  logic [NREQ-1:0]   ready_a, ready_b;
  logic              busy_a, busy_b;
  logic              we_a, we_b;
  logic [4:0]        waddr_a, waddr_b;
  logic [XL-1:0]     wdata_a, wdata_b;

  rf_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(XL), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(va), .req_addr(aa), .req_data(da),
    .req_ready(ready_a), .init_busy(busy_a),
    .rf_we(we_a), .rf_waddr(waddr_a), .rf_wdata(wdata_a)
  );

  rf_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(XL), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vb), .req_addr(ab), .req_data(db),
    .req_ready(ready_b), .init_busy(busy_b),
    .rf_we(we_b), .rf_waddr(waddr_b), .rf_wdata(wdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_init();
    for (int r = 1; r < 32; r++) exp_q.push_back({5'(r), 32'h0});
  endtask

  // Monitor: every write strobe seen by the register file must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && we_a) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'h0, waddr_a, wdata_a}, 64'h0);
      end else begin
        chk("wr_port", {27'h0, waddr_a, wdata_a}, {27'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    logic ready_seen;
    logic done;
    int n0, n1;

    rst_n = 1'b0;
    va = '0; aa = '0; da = '0;
    vb = '0; ab = '0; db = '0;
    repeat (2) @(negedge clk);
    chk("rst_we",     we_a, 0);
    chk("rst_waddr",  waddr_a, 0);
    chk("rst_wdata",  wdata_a, 0);
    chk("rst_busy_a", busy_a, 1);
    chk("rst_ready",  ready_a, 0);
    chk("rst_busy_b", busy_b, 0);

    // Release; both builds get a request in the very first cycle.
    rst_n = 1'b1;
    push_init();
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    va = 2'b01; aa = {5'd0, 5'd5};  da = {32'h0, 32'hDEADBEEF};
    vb = 2'b01; ab = {5'd0, 5'd31}; db = {32'h0, 32'h1};
    #1;
    chk("b_ready_first", ready_b, 2'b01);
    chk("a_ready_init",  ready_a, 2'b00);
    busy_cnt = busy_a ? 1 : 0;
    @(posedge clk); #1;
    vb = '0;
    @(negedge clk);
    chk("b_we",    we_b, 1);
    chk("b_waddr", waddr_b, 31);
    chk("b_wdata", wdata_b, 32'h1);
    chk("b_busy",  busy_b, 0);

    ready_seen = 1'b0;
    done = 1'b0;
    if (busy_a) busy_cnt++;
    if (ready_a != 0) ready_seen = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (busy_a) begin
        busy_cnt++;
        if (ready_a != 0) ready_seen = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    chk("init_done",        done, 1);
    chk("init_busy_cycles", busy_cnt, 31);
    chk("init_ready_zero",  ready_seen, 0);
    chk("first_arb_ready",  ready_a, 2'b01);
    @(posedge clk); #1;
    va = '0;

    // x0 write: accepted, no strobe, pointer moves back to 0.
    @(negedge clk);
    va = 2'b10; aa = {5'd0, 5'd0}; da = {32'h55, 32'h0};
    #1;
    chk("x0_ready", ready_a, 2'b10);
    @(posedge clk); #1;
    va = '0;
    @(negedge clk);
    chk("x0_no_we", we_a, 0);
    va = 2'b10; aa = {5'd7, 5'd0}; da = {32'h77, 32'h0};
    exp_q.push_back({5'd7, 32'h77});
    #1;
    chk("x7_ready", ready_a, 2'b10);
    @(posedge clk); #1;
    va = '0;

    // Both valid: pointer is 0, so grants go 0,1,0,1,0,1 back-to-back.
    @(negedge clk);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({5'd3, 32'h100 + 32'(k)});
      exp_q.push_back({5'd4, 32'h200 + 32'(k)});
    end
    va = 2'b11; aa = {5'd4, 5'd3};
    da = {32'h200, 32'h100};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", ready_a, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      if (c % 2 == 0) n0++; else n1++;
      da = {32'h200 + 32'(n1), 32'h100 + 32'(n0)};
      if (c == 5) va = '0;
      @(negedge clk);
      chk("rr_no_bubble", we_a, 1);
    end

    // Reset mid-write of x9: strobe must vanish before the falling edge.
    va = 2'b01; aa = {5'd0, 5'd9}; da = {32'h0, 32'h99};
    @(posedge clk); #1;
    va = '0;
    chk("x9_write_live", {we_a, waddr_a}, {1'b1, 5'd9});
    rst_n = 1'b0;
    #1;
    chk("async_we",    we_a, 0);
    chk("async_waddr", waddr_a, 0);
    chk("async_busy",  busy_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_init();
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!busy_a) done = 1'b1;
    end
    chk("reinit_done", done, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
